// File: rtl/core_io_bridge.sv
// core_io_bridge: packs UART RX bytes into core words on request and unpacks
// core output words into a TX byte queue. Both queues are register FIFOs
// with power-of-two depth; byte order on the wire is set by LITTLE_ENDIAN.
module core_io_bridge #(
    parameter int WORD_BYTES    = 4,
    parameter int RX_DEPTH      = 16,
    parameter int TX_DEPTH      = 16,
    parameter bit LITTLE_ENDIAN = 1'b1,
    localparam int DATA_W       = 8 * WORD_BYTES
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              input_req,
    output logic [DATA_W-1:0] input_data,
    output logic              input_valid,
    input  logic [DATA_W-1:0] output_data,
    input  logic              output_valid,
    output logic              io_stall,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              rx_overflow
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);
    localparam logic [RAW:0] RX_WB   = (RAW+1)'(WORD_BYTES);
    localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);
    localparam logic [TAW:0] TX_WB   = (TAW+1)'(WORD_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state_q, state_d;

    logic [7:0]        rx_mem_q [RX_DEPTH];
    logic [RAW-1:0]    rx_wr_q, rx_rd_q;
    logic [RAW:0]      rx_cnt_q, rx_cnt_d;
    logic [7:0]        tx_mem_q [TX_DEPTH];
    logic [TAW-1:0]    tx_wr_q, tx_rd_q;
    logic [TAW:0]      tx_cnt_q, tx_cnt_d, tx_free;
    logic [DATA_W-1:0] input_data_q, word_d;
    logic              rx_overflow_q;
    logic              rx_push, rx_pop, tx_accept, tx_pop;

    // Queue handshakes; "full"/"free" are judged on pre-pop occupancy.
    always_comb begin
        rx_push   = rx_valid && (rx_cnt_q != RX_FULL);
        rx_pop    = (state_q == WAIT) && (rx_cnt_q >= RX_WB);
        tx_free   = TX_FULL - tx_cnt_q;
        tx_accept = output_valid && (tx_free >= TX_WB);
        tx_valid  = (tx_cnt_q != '0);
        tx_pop    = tx_valid && tx_ready;
        tx_data   = tx_mem_q[tx_rd_q];
        rx_cnt_d  = rx_cnt_q + {{RAW{1'b0}}, rx_push} - (rx_pop ? RX_WB : '0);
        tx_cnt_d  = tx_cnt_q + (tx_accept ? TX_WB : '0) - {{TAW{1'b0}}, tx_pop};
    end

    // Gather the oldest WORD_BYTES RX bytes into a word in wire order.
    always_comb begin
        word_d = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (LITTLE_ENDIAN)
                word_d[8*i +: 8] = rx_mem_q[rx_rd_q + RAW'(i)];
            else
                word_d[8*(WORD_BYTES-1-i) +: 8] = rx_mem_q[rx_rd_q + RAW'(i)];
        end
    end

    // Read FSM next state and core-facing status.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (input_req) state_d = WAIT;
            WAIT:    if (rx_pop)    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        input_valid = (state_q == RESP);
        io_stall    = (state_q == WAIT) || ((state_q == IDLE) && input_req)
                   || (output_valid && !(tx_free >= TX_WB));
    end

    assign input_data  = input_data_q;
    assign rx_overflow = rx_overflow_q;

    // Control state: FSM, pointers, counts, response word, overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            rx_wr_q       <= '0;
            rx_rd_q       <= '0;
            rx_cnt_q      <= '0;
            tx_wr_q       <= '0;
            tx_rd_q       <= '0;
            tx_cnt_q      <= '0;
            input_data_q  <= '0;
            rx_overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            if (rx_push)   rx_wr_q <= rx_wr_q + RAW'(1);
            if (rx_pop)    rx_rd_q <= rx_rd_q + RAW'(WORD_BYTES);
            if (rx_pop)    input_data_q <= word_d;
            if (rx_valid && !rx_push) rx_overflow_q <= 1'b1;
            if (tx_accept) tx_wr_q <= tx_wr_q + TAW'(WORD_BYTES);
            if (tx_pop)    tx_rd_q <= tx_rd_q + TAW'(1);
        end
    end

    // FIFO storage; contents need no reset since the counts gate all reads.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wr_q] <= rx_data;
        if (tx_accept) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (LITTLE_ENDIAN)
                    tx_mem_q[tx_wr_q + TAW'(i)] <= output_data[8*i +: 8];
                else
                    tx_mem_q[tx_wr_q + TAW'(i)] <= output_data[8*(WORD_BYTES-1-i) +: 8];
            end
        end
    end
endmodule

// File: tb/tb_core_io_bridge.sv
// Bench for core_io_bridge: instance 0 is little-endian with 16-deep FIFOs,
// instance 1 is big-endian with 4-deep FIFOs. A byte/word scoreboard holds
// expected results as stimulus is applied.
module tb_core_io_bridge;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rx_data [2];
    logic        rx_valid [2];
    logic        input_req [2];
    logic [31:0] output_data [2];
    logic        output_valid [2];
    logic        tx_ready [2];

    logic [31:0] a_in_data, b_in_data;
    logic        a_in_valid, b_in_valid, a_stall, b_stall, a_txv, b_txv, a_ovf, b_ovf;
    logic [7:0]  a_txd, b_txd;

    logic [31:0] in_data [2];
    logic        in_valid [2], stall [2], txv [2], ovf [2];
    logic [7:0]  txd [2];

    always_comb begin
        in_data[0] = a_in_data;   in_data[1] = b_in_data;
        in_valid[0] = a_in_valid; in_valid[1] = b_in_valid;
        stall[0] = a_stall;       stall[1] = b_stall;
        txv[0] = a_txv;           txv[1] = b_txv;
        ovf[0] = a_ovf;           ovf[1] = b_ovf;
        txd[0] = a_txd;           txd[1] = b_txd;
    end

    core_io_bridge #(.WORD_BYTES(4), .RX_DEPTH(16), .TX_DEPTH(16), .LITTLE_ENDIAN(1'b1)) dut_a (
        .clk(clk), .rstn(rstn), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .input_req(input_req[0]), .input_data(a_in_data), .input_valid(a_in_valid),
        .output_data(output_data[0]), .output_valid(output_valid[0]), .io_stall(a_stall),
        .tx_data(a_txd), .tx_valid(a_txv), .tx_ready(tx_ready[0]), .rx_overflow(a_ovf));

    core_io_bridge #(.WORD_BYTES(4), .RX_DEPTH(4), .TX_DEPTH(4), .LITTLE_ENDIAN(1'b0)) dut_b (
        .clk(clk), .rstn(rstn), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .input_req(input_req[1]), .input_data(b_in_data), .input_valid(b_in_valid),
        .output_data(output_data[1]), .output_valid(output_valid[1]), .io_stall(b_stall),
        .tx_data(b_txd), .tx_valid(b_txv), .tx_ready(tx_ready[1]), .rx_overflow(b_ovf));

    // Scoreboard / reference model state
    logic [7:0]  mdl_rx [$];
    logic [7:0]  mdl_tx [$];
    logic [31:0] exp_word [$];
    logic        mdl_ovf;

    function automatic int depth_of(int d);
        return (d == 0) ? 16 : 4;
    endfunction

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int d = 0; d < 2; d++) begin
            rx_valid[d] = 1'b0; rx_data[d] = 8'h00; input_req[d] = 1'b0;
            output_data[d] = 32'h0; output_valid[d] = 1'b0; tx_ready[d] = 1'b0;
        end
        rstn = 1'b0;
        mdl_rx.delete(); mdl_tx.delete(); exp_word.delete(); mdl_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic push(int d, logic [7:0] b);
        rx_valid[d] = 1'b1; rx_data[d] = b;
        if (mdl_rx.size() < depth_of(d)) mdl_rx.push_back(b); else mdl_ovf = 1'b1;
        cycle();
        rx_valid[d] = 1'b0;
    endtask

    // Model the word the next read will return.
    task automatic req_word(int d);
        logic [7:0] b0, b1, b2, b3;
        b0 = mdl_rx.pop_front(); b1 = mdl_rx.pop_front();
        b2 = mdl_rx.pop_front(); b3 = mdl_rx.pop_front();
        exp_word.push_back((d == 0) ? {b3, b2, b1, b0} : {b0, b1, b2, b3});
    endtask

    // Model the wire bytes a written word becomes.
    task automatic tx_expect(int d, logic [31:0] w);
        for (int i = 0; i < 4; i++)
            mdl_tx.push_back((d == 0) ? w[8*i +: 8] : w[8*(3-i) +: 8]);
    endtask

    task automatic test_reset();
        do_reset();
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++; if (in_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_input_valid d=%0d got %b exp 0", d, in_valid[d]); end
            checks++; if (stall[d] !== 1'b0) begin errors++; $display("FAIL reset_io_stall d=%0d got %b exp 0", d, stall[d]); end
            checks++; if (txv[d] !== 1'b0) begin errors++; $display("FAIL reset_tx_valid d=%0d got %b exp 0", d, txv[d]); end
            checks++; if (ovf[d] !== 1'b0) begin errors++; $display("FAIL reset_rx_overflow d=%0d got %b exp 0", d, ovf[d]); end
            checks++; if (in_data[d] !== 32'h0) begin errors++; $display("FAIL reset_input_data d=%0d got %h exp 0", d, in_data[d]); end
        end
        cycle();
    endtask

    task automatic test_byte_order();
        logic [31:0] e;
        for (int d = 0; d < 2; d++) begin
            do_reset();
            push(d, 8'h11); push(d, 8'h22); push(d, 8'h33); push(d, 8'h44);
            input_req[d] = 1'b1; req_word(d);
            sample();
            checks++; if (stall[d] !== 1'b1 || in_valid[d] !== 1'b0) begin errors++; $display("FAIL order_t d=%0d got stall=%b valid=%b exp 1/0", d, stall[d], in_valid[d]); end
            cycle(); input_req[d] = 1'b0;
            sample();
            checks++; if (stall[d] !== 1'b1 || in_valid[d] !== 1'b0) begin errors++; $display("FAIL order_t1 d=%0d got stall=%b valid=%b exp 1/0", d, stall[d], in_valid[d]); end
            cycle(); sample();
            e = exp_word.pop_front();
            checks++; if (in_valid[d] !== 1'b1 || stall[d] !== 1'b0) begin errors++; $display("FAIL order_t2 d=%0d got valid=%b stall=%b exp 1/0", d, in_valid[d], stall[d]); end
            checks++; if (in_data[d] !== e) begin errors++; $display("FAIL order_data d=%0d got %h exp %h", d, in_data[d], e); end
            cycle(); sample();
            checks++; if (in_valid[d] !== 1'b0 || in_data[d] !== e) begin errors++; $display("FAIL order_hold d=%0d got valid=%b data=%h exp 0/%h", d, in_valid[d], in_data[d], e); end
            cycle();
        end
    endtask

    task automatic test_wait_stall();
        logic [31:0] e;
        do_reset();
        input_req[0] = 1'b1;
        sample(); cycle(); input_req[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sample();
            checks++; if ({stall[0], in_valid[0]} !== 2'b10) begin errors++; $display("FAIL wait_idle k=%0d got stall/valid=%b exp 10", k, {stall[0], in_valid[0]}); end
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            rx_valid[0] = 1'b1; rx_data[0] = 8'h60 + 8'(i); mdl_rx.push_back(rx_data[0]);
            sample();
            checks++; if ({stall[0], in_valid[0]} !== 2'b10) begin errors++; $display("FAIL wait_fill i=%0d got stall/valid=%b exp 10", i, {stall[0], in_valid[0]}); end
            cycle();
        end
        rx_valid[0] = 1'b0;
        req_word(0);
        sample();
        checks++; if ({stall[0], in_valid[0]} !== 2'b10) begin errors++; $display("FAIL wait_pop got stall/valid=%b exp 10", {stall[0], in_valid[0]}); end
        cycle(); sample();
        e = exp_word.pop_front();
        checks++; if (in_valid[0] !== 1'b1 || in_data[0] !== e) begin errors++; $display("FAIL wait_resp got valid=%b data=%h exp 1/%h", in_valid[0], in_data[0], e); end
        cycle();
    endtask

    task automatic test_push_during_pop();
        logic [31:0] e;
        bit got;
        do_reset();
        for (int i = 1; i <= 5; i++) push(0, 8'(i));
        input_req[0] = 1'b1; req_word(0);
        sample(); cycle(); input_req[0] = 1'b0;
        rx_valid[0] = 1'b1; rx_data[0] = 8'h06; mdl_rx.push_back(8'h06);
        sample(); cycle(); rx_valid[0] = 1'b0;
        sample();
        e = exp_word.pop_front();
        checks++; if (in_valid[0] !== 1'b1 || in_data[0] !== e) begin errors++; $display("FAIL pushpop_w1 got valid=%b data=%h exp 1/%h", in_valid[0], in_data[0], e); end
        cycle();
        push(0, 8'h07); push(0, 8'h08);
        input_req[0] = 1'b1; req_word(0);
        sample(); cycle(); input_req[0] = 1'b0;
        e = exp_word.pop_front();
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            sample();
            if (in_valid[0]) begin
                got = 1'b1;
                checks++; if (in_data[0] !== e) begin errors++; $display("FAIL pushpop_w2 got %h exp %h", in_data[0], e); end
            end
            cycle();
        end
        checks++; if (!got) begin errors++; $display("FAIL pushpop_timeout got no input_valid exp one within 8 cycles"); end
    endtask

    task automatic test_write_le();
        do_reset();
        tx_ready[0] = 1'b1;
        output_valid[0] = 1'b1; output_data[0] = 32'hDEADBEEF;
        tx_expect(0, output_data[0]);
        sample();
        checks++; if (stall[0] !== 1'b0 || txv[0] !== 1'b0) begin errors++; $display("FAIL wr_accept got stall=%b txv=%b exp 0/0", stall[0], txv[0]); end
        cycle(); output_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] eb;
            sample();
            eb = mdl_tx.pop_front();
            checks++; if (txv[0] !== 1'b1 || txd[0] !== eb) begin errors++; $display("FAIL wr_byte i=%0d got valid=%b data=%h exp 1/%h", i, txv[0], txd[0], eb); end
            cycle();
        end
        sample();
        checks++; if (txv[0] !== 1'b0) begin errors++; $display("FAIL wr_drain got txv=%b exp 0", txv[0]); end
        cycle();
    endtask

    task automatic test_tx_backpressure();
        bit acc, acc2, exp_st, pop;
        do_reset();
        output_valid[1] = 1'b1; output_data[1] = 32'hA1B2C3D4;
        sample();
        checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL bp_first got stall=%b exp 0", stall[1]); end
        tx_expect(1, output_data[1]);
        cycle();
        output_data[1] = 32'h01020304;
        acc2 = 1'b0;
        for (int k = 0; k < 40 && (!acc2 || mdl_tx.size() != 0); k++) begin
            if (k == 3) tx_ready[1] = 1'b1;
            sample();
            exp_st = output_valid[1] && ((4 - int'(mdl_tx.size())) < 4);
            checks++; if (stall[1] !== exp_st) begin errors++; $display("FAIL bp_stall k=%0d got %b exp %b", k, stall[1], exp_st); end
            checks++; if (txv[1] !== (mdl_tx.size() != 0)) begin errors++; $display("FAIL bp_txv k=%0d got %b exp %b", k, txv[1], mdl_tx.size() != 0); end
            if (mdl_tx.size() != 0) begin
                checks++; if (txd[1] !== mdl_tx[0]) begin errors++; $display("FAIL bp_data k=%0d got %h exp %h", k, txd[1], mdl_tx[0]); end
            end
            acc = output_valid[1] && !exp_st;
            pop = tx_ready[1] && (mdl_tx.size() != 0);
            if (pop) void'(mdl_tx.pop_front());
            if (acc) tx_expect(1, output_data[1]);
            cycle();
            if (acc) begin output_valid[1] = 1'b0; acc2 = 1'b1; end
        end
        checks++; if (!acc2 || mdl_tx.size() != 0) begin errors++; $display("FAIL bp_timeout got accepted=%b left=%0d exp 1/0", acc2, mdl_tx.size()); end
    endtask

    task automatic test_overflow();
        logic [31:0] e;
        bit got;
        do_reset();
        push(1, 8'h51); push(1, 8'h52); push(1, 8'h53); push(1, 8'h54);
        sample();
        checks++; if (ovf[1] !== 1'b0) begin errors++; $display("FAIL ovf_full got %b exp 0", ovf[1]); end
        cycle();
        push(1, 8'h55);
        sample();
        checks++; if (ovf[1] !== mdl_ovf) begin errors++; $display("FAIL ovf_set got %b exp %b", ovf[1], mdl_ovf); end
        cycle();
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin push(1, 8'h61); push(1, 8'h62); push(1, 8'h63); push(1, 8'h64); end
            input_req[1] = 1'b1; req_word(1);
            sample(); cycle(); input_req[1] = 1'b0;
            e = exp_word.pop_front();
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                sample();
                if (in_valid[1]) begin
                    got = 1'b1;
                    checks++; if (in_data[1] !== e) begin errors++; $display("FAIL ovf_word r=%0d got %h exp %h", r, in_data[1], e); end
                end
                cycle();
            end
            checks++; if (!got) begin errors++; $display("FAIL ovf_timeout r=%0d got no input_valid exp one within 8 cycles", r); end
        end
        sample();
        checks++; if (ovf[1] !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf[1]); end
        cycle();
        input_req[1] = 1'b1;
        sample(); cycle(); input_req[1] = 1'b0;
        sample();
        checks++; if (stall[1] !== 1'b1) begin errors++; $display("FAIL midwait_pre got stall=%b exp 1", stall[1]); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (stall[1] !== 1'b0 || ovf[1] !== 1'b0 || in_valid[1] !== 1'b0) begin errors++; $display("FAIL midwait_rst got stall=%b ovf=%b valid=%b exp 0/0/0", stall[1], ovf[1], in_valid[1]); end
        @(posedge clk); #1 rstn = 1'b1;
        mdl_rx.delete(); mdl_ovf = 1'b0;
        cycle(); sample();
        checks++; if (stall[1] !== 1'b0 || in_valid[1] !== 1'b0) begin errors++; $display("FAIL midwait_idle got stall=%b valid=%b exp 0/0", stall[1], in_valid[1]); end
        cycle();
    endtask

    // Core must never request a read and a write in the same cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rstn === 1'b1 && input_req[d] === 1'b1 && output_valid[d] === 1'b1) begin
                errors++;
                $display("FAIL protocol d=%0d got input_req and output_valid together exp exclusive", d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200us");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        test_reset();
        test_byte_order();
        test_wait_stall();
        test_push_during_pop();
        test_write_le();
        test_tx_backpressure();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
